// File: rtl/latex_line_matcher_pkg.sv
// Shared types, constants and signature-table generation for the LaTeX line matcher.
// The signature table is derived from the line text table at elaboration, so text and signatures cannot drift apart.
package latex_line_matcher_pkg;

  localparam int          LINES      = 51;
  localparam int          TEXT_BYTES = 40;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam logic [5:0]  NO_MATCH   = 6'h3F;

  typedef enum logic [1:0] {IDLE, RECV, LOOKUP, DONE} state_t;

  typedef struct packed {
    logic [15:0] crc;
    logic [9:0]  len;
  } sig_entry_t;

  typedef sig_entry_t [LINES-1:0] sig_table_t;

  // One full byte through CRC-16/CCITT-FALSE, MSB first, no reflection.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [8*TEXT_BYTES-1:0] line_text(input int idx);
    logic [8*TEXT_BYTES-1:0] t;
    t = '0;
    case (idx)
      0:  t = "1";
      1:  t = "\\frac{1}{s}";
      2:  t = "t";
      3:  t = "\\frac{1}{s^2}";
      4:  t = "t^n";
      5:  t = "\\frac{n!}{s^{n+1}}";
      6:  t = "e^{at}";
      7:  t = "\\frac{1}{s-a}";
      8:  t = "\\sin(\\omega t)";
      9:  t = "\\frac{\\omega}{s^2+\\omega^2}";
      10: t = "\\cos(\\omega t)";
      11: t = "\\frac{s}{s^2+\\omega^2}";
      12: t = "\\sinh(at)";
      13: t = "\\frac{a}{s^2-a^2}";
      14: t = "\\cosh(at)";
      15: t = "\\frac{s}{s^2-a^2}";
      16: t = "te^{at}";
      17: t = "\\frac{1}{(s-a)^2}";
      18: t = "t^ne^{at}";
      19: t = "\\frac{n!}{(s-a)^{n+1}}";
      20: t = "e^{at}\\sin(bt)";
      21: t = "\\frac{b}{(s-a)^2+b^2}";
      22: t = "e^{at}\\cos(bt)";
      23: t = "\\frac{s-a}{(s-a)^2+b^2}";
      24: t = "t\\sin(\\omega t)";
      25: t = "\\frac{2\\omega s}{(s^2+\\omega^2)^2}";
      26: t = "t\\cos(\\omega t)";
      27: t = "\\frac{s^2-\\omega^2}{(s^2+\\omega^2)^2}";
      28: t = "\\delta(t)";
      29: t = "u(t-a)";
      30: t = "\\frac{e^{-as}}{s}";
      31: t = "\\delta(t-a)";
      32: t = "e^{-as}";
      33: t = "f'(t)";
      34: t = "sF(s)-f(0)";
      35: t = "f''(t)";
      36: t = "s^2F(s)-sf(0)-f'(0)";
      37: t = "\\int_0^t f(\\tau)d\\tau";
      38: t = "\\frac{F(s)}{s}";
      39: t = "tf(t)";
      40: t = "-F'(s)";
      41: t = "e^{at}f(t)";
      42: t = "F(s-a)";
      43: t = "f(t-a)u(t-a)";
      44: t = "e^{-as}F(s)";
      45: t = "(f*g)(t)";
      46: t = "F(s)G(s)";
      47: t = "\\frac{f(t)}{t}";
      48: t = "\\int_s^\\infty F(u)du";
      49: t = "f(at)";
      50: t = "\\frac{1}{a}F(\\frac{s}{a})";
      default: t = '0;
    endcase
    return t;
  endfunction

  // Text is right-aligned in the vector, so leading zero bytes are padding.
  function automatic sig_table_t build_table();
    sig_table_t              tbl;
    logic [8*TEXT_BYTES-1:0] txt;
    logic [7:0]              ch;
    logic [15:0]             c;
    logic [9:0]              l;
    tbl = '0;
    for (int n = 0; n < LINES; n++) begin
      txt = line_text(n);
      c   = CRC_INIT;
      l   = '0;
      for (int i = TEXT_BYTES-1; i >= 0; i--) begin
        ch = txt[8*i +: 8];
        if (ch != 8'h00) begin
          c = crc_byte(c, ch);
          l = l + 10'd1;
        end
      end
      tbl[n] = {c, l};
    end
    return tbl;
  endfunction

endpackage

// File: rtl/latex_line_matcher_if.sv
// Character stream and result bus of the LaTeX line matcher.
interface latex_line_matcher_if;
  logic        start;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        done;
  logic        match;
  logic [5:0]  line_out;
  logic [15:0] crc_out;
  logic [9:0]  len_out;
  logic        err;

  modport master (
    output start, char_in, char_valid,
    input  char_ready, busy, done, match, line_out, crc_out, len_out, err
  );

  modport slave (
    input  start, char_in, char_valid,
    output char_ready, busy, done, match, line_out, crc_out, len_out, err
  );
endinterface

// File: rtl/latex_line_matcher_sig_rom.sv
// Combinational signature lookup: line index -> {crc, len}.
// With LEN_CHECK_EN undefined the length field reads as zero so only the CRC discriminates.
module latex_line_matcher_sig_rom
  import latex_line_matcher_pkg::*;
(
  input  logic [5:0]  idx,
  output sig_entry_t  entry
);

  localparam sig_table_t TABLE = build_table();

  always_comb begin
    entry = '0;
    if (int'(idx) < LINES) begin
      entry = TABLE[idx];
`ifndef LEN_CHECK_EN
      entry.len = '0;
`endif
    end
  end

endmodule

// File: rtl/latex_line_matcher.sv
// Hashes an incoming LaTeX character stream and searches the signature ROM for the matching line.
// Optional macro LEN_CHECK_EN: a hit additionally requires the character count to match.
module latex_line_matcher
  import latex_line_matcher_pkg::*;
#(
  parameter int          NUM_LINES = LINES,
  parameter int          MAX_CHARS = 1023,
  parameter logic [7:0]  TERM_CHAR = 8'h00
)(
  input  logic                 clk,
  input  logic                 rst_n,
  latex_line_matcher_if.slave  bus
);

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [9:0]  len_q, len_d;
  logic [5:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        match_q, match_d;
  logic [5:0]  line_q, line_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic [9:0]  len_out_q, len_out_d;

  sig_entry_t  rom_entry;
  logic [9:0]  len_key;
  logic        hit;

  latex_line_matcher_sig_rom u_sig_rom (
    .idx   (idx_q),
    .entry (rom_entry)
  );

`ifdef LEN_CHECK_EN
  assign len_key = len_q;
`else
  assign len_key = '0;
`endif

  assign hit = (rom_entry == {crc_q, len_key});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= CRC_INIT;
      len_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      match_q   <= 1'b0;
      line_q    <= NO_MATCH;
      crc_out_q <= CRC_INIT;
      len_out_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      match_q   <= match_d;
      line_q    <= line_d;
      crc_out_q <= crc_out_d;
      len_out_q <= len_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    idx_d     = idx_q;
    err_d     = err_q;
    match_d   = match_q;
    line_d    = line_q;
    crc_out_d = crc_out_q;
    len_out_d = len_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RECV;
          crc_d   = CRC_INIT;
          len_d   = '0;
          err_d   = 1'b0;
          match_d = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RECV: begin
        if (bus.start) begin
          crc_d = CRC_INIT;
          len_d = '0;
          err_d = 1'b1;
        end else if (bus.char_valid) begin
          if (bus.char_in == TERM_CHAR) begin
            state_d = LOOKUP;
            idx_d   = '0;
          end else if (len_q == 10'(MAX_CHARS)) begin
            // Overflowing byte is neither hashed nor counted.
            state_d   = DONE;
            err_d     = 1'b1;
            match_d   = 1'b0;
            line_d    = NO_MATCH;
            crc_out_d = crc_q;
            len_out_d = len_q;
          end else begin
            crc_d = crc_byte(crc_q, bus.char_in);
            len_d = len_q + 10'd1;
          end
        end
      end

      LOOKUP: begin
        if (bus.start) begin
          state_d = RECV;
          crc_d   = CRC_INIT;
          len_d   = '0;
          err_d   = 1'b1;
        end else if (hit || idx_q == 6'(NUM_LINES-1)) begin
          state_d   = DONE;
          match_d   = hit;
          line_d    = hit ? idx_q : NO_MATCH;
          crc_out_d = crc_q;
          len_out_d = len_q;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.char_ready = (state_q == RECV);
  assign bus.busy       = (state_q == RECV) || (state_q == LOOKUP);
  assign bus.done       = (state_q == DONE);
  assign bus.match      = match_q;
  assign bus.line_out   = line_q;
  assign bus.crc_out    = crc_out_q;
  assign bus.len_out    = len_out_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_latex_line_matcher.sv
// Directed scoreboard bench for latex_line_matcher: stimulus pushes expected results, a monitor checks each done pulse.
module tb_latex_line_matcher;

  logic clk;
  logic rst_n;

  latex_line_matcher_if bus ();

  latex_line_matcher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        m;
    logic [5:0]  line;
    logic [15:0] crc;
    bit          chk_crc;
    logic [9:0]  len;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference CRC-16/CCITT-FALSE, byte-wise high-byte XOR form.
  function automatic logic [15:0] crc_model(input string s);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < s.len(); i++) begin
      c = c ^ {s[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1, required no result pending");
      end else begin
        e = sb.pop_front();
        check({e.name, "_match"}, bus.match, e.m);
        check({e.name, "_line"}, bus.line_out, e.line);
        check({e.name, "_len"}, bus.len_out, e.len);
        check({e.name, "_err"}, bus.err, e.e);
        if (e.chk_crc) check({e.name, "_crc"}, bus.crc_out, e.crc);
      end
    end
  end

  task automatic push(input string name, input logic m, input logic [5:0] line,
                      input logic [15:0] crc, input bit chk_crc, input logic [9:0] len, input logic e);
    exp_t x;
    x.name = name; x.m = m; x.line = line; x.crc = crc;
    x.chk_crc = chk_crc; x.len = len; x.e = e;
    sb.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.char_in    = b;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL char_ready_timeout: char_ready=0, required 1 within 100 cycles");
    end
    @(posedge clk);
    #1 bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_done(input string name, input int limit, output int lat);
    lat = 0;
    while (!bus.done && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done=0, required 1 within %0d cycles", name, limit);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_char_ready"}, bus.char_ready, 1'b0);
    check({name, "_busy"}, bus.busy, 1'b0);
    check({name, "_done"}, bus.done, 1'b0);
    check({name, "_match"}, bus.match, 1'b0);
    check({name, "_err"}, bus.err, 1'b0);
    check({name, "_line"}, bus.line_out, 6'h3F);
    check({name, "_crc"}, bus.crc_out, 16'hFFFF);
    check({name, "_len"}, bus.len_out, 10'd0);
  endtask

  initial begin
    int    lat;
    string l7, l0, l50;
    l7  = "\\frac{1}{s-a}";
    l0  = "1";
    l50 = "\\frac{1}{a}F(\\frac{s}{a})";

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known CRC check vector, not in the table
    pulse_start();
    send_str("123456789");
    push("check_vec", 1'b0, 6'h3F, 16'h29B1, 1'b1, 10'd9, 1'b0);
    send_byte(8'h00);
    wait_done("check_vec", 60, lat);

    // Empty frame
    pulse_start();
    push("empty", 1'b0, 6'h3F, 16'hFFFF, 1'b1, 10'd0, 1'b0);
    send_byte(8'h00);
    wait_done("empty", 60, lat);
    check("empty_latency_ok", (lat <= 53), 1'b1);

    // Overflow: 1024th non-terminator byte
    pulse_start();
    push("overflow", 1'b0, 6'h3F, 16'h0000, 1'b0, 10'd1023, 1'b1);
    for (int i = 0; i < 1024; i++) send_byte(8'h61);
    check("overflow_ready_low", bus.char_ready, 1'b0);
    wait_done("overflow", 5, lat);
    check("overflow_ready_idle", bus.char_ready, 1'b0);

    // Restart mid-frame
    pulse_start();
    send_str("abc");
    pulse_start();
    check("restart_err_flag", bus.err, 1'b1);
    check("restart_busy", bus.busy, 1'b1);
    send_str("A");
    push("restart", 1'b0, 6'h3F, 16'hB915, 1'b1, 10'd1, 1'b1);
    send_byte(8'h00);
    wait_done("restart", 60, lat);

    // char_valid in IDLE ignored, then line 0
    @(negedge clk);
    bus.char_in    = 8'h78;
    bus.char_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_low", bus.char_ready, 1'b0);
    bus.char_valid = 1'b0;
    pulse_start();
    send_str(l0);
    push("line0", 1'b1, 6'd0, crc_model(l0), 1'b1, 10'd1, 1'b0);
    send_byte(8'h00);
    wait_done("line0", 60, lat);

    // Line 7
    pulse_start();
    send_str(l7);
    push("line7", 1'b1, 6'd7, crc_model(l7), 1'b1, 10'd13, 1'b0);
    send_byte(8'h00);
    wait_done("line7", 60, lat);
    check("line7_latency_ok", (lat <= 53), 1'b1);

    // Last table entry
    pulse_start();
    send_str(l50);
    push("line50", 1'b1, 6'd50, crc_model(l50), 1'b1, 10'd25, 1'b0);
    send_byte(8'h00);
    wait_done("line50", 60, lat);
    check("line50_latency_ok", (lat <= 53), 1'b1);

    // Asynchronous reset during LOOKUP
    pulse_start();
    send_str("zz");
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("lookup_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // Normal frame after reset
    pulse_start();
    send_str(l7);
    push("after_rst", 1'b1, 6'd7, crc_model(l7), 1'b1, 10'd13, 1'b0);
    send_byte(8'h00);
    wait_done("after_rst", 60, lat);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
